// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, requester ids and width constants for the memory port arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    localparam logic REQ_IF     = 1'b0;
    localparam logic REQ_D      = 1'b1;
    localparam int   ADDR_W_DEF = 32;
    localparam int   DATA_W_DEF = 32;
    localparam int   CNT_W      = 4;
endpackage

// File: rtl/mem_arb_priority.sv
// mem_arb_priority: data-first winner select; a saturating streak of data grants forces a fetch grant.
module mem_arb_priority
    import mem_arb_pkg::*;
#(
    parameter int MAX_STREAK = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req,
    input  logic d_req,
    input  logic grant_fire,
    output logic winner
);
    logic [CNT_W-1:0] streak_q, streak_d;
    logic             starved;

    assign starved = if_req && (streak_q == MAX_STREAK[CNT_W-1:0]);
    assign winner  = (d_req && !starved) ? REQ_D : REQ_IF;

    always_comb begin
        streak_d = streak_q;
        if (grant_fire)
            streak_d = (winner == REQ_D && if_req) ? (starved ? streak_q : streak_q + 1'b1) : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) streak_q <= '0;
        else        streak_q <= streak_d;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and load/store,
// one transaction in flight, data first with a bounded fetch starvation window.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int MEM_LATENCY = 1,
    parameter int MAX_STREAK  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             id_q, id_d, we_q, we_d, win, fire;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
    logic             if_rv_q, if_rv_d, d_rv_q, d_rv_d;

    assign fire = (state_q == IDLE) && (if_req || d_req);

    mem_arb_priority #(.MAX_STREAK(MAX_STREAK)) u_prio (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .d_req      (d_req),
        .grant_fire (fire),
        .winner     (win)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        id_d       = id_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_rv_d    = 1'b0;
        d_rv_d     = 1'b0;
        case (state_q)
            IDLE: if (fire) begin
                state_d = ISSUE;
                id_d    = win;
                we_d    = (win == REQ_D) && d_we;
                addr_d  = (win == REQ_D) ? d_addr : if_addr;
                wdata_d = (win == REQ_D) ? d_wdata : wdata_q;
            end
            ISSUE: begin
                state_d = we_q ? IDLE : WAIT;
                cnt_d   = MEM_LATENCY[CNT_W-1:0];
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                // Last wait cycle: mem_rdata is valid now, rvalid follows in IDLE
                if (cnt_q == 4'd1) begin
                    state_d    = IDLE;
                    if_rv_d    = (id_q == REQ_IF);
                    d_rv_d     = (id_q == REQ_D);
                    if_rdata_d = (id_q == REQ_IF) ? mem_rdata : if_rdata_q;
                    d_rdata_d  = (id_q == REQ_D) ? mem_rdata : d_rdata_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            id_q       <= REQ_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_rv_q    <= 1'b0;
            d_rv_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            id_q       <= id_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if_rv_q    <= if_rv_d;
            d_rv_q     <= d_rv_d;
        end
    end

    assign mem_en    = (state_q == ISSUE);
    assign mem_we    = mem_en && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_gnt    = mem_en && (id_q == REQ_IF);
    assign d_gnt     = mem_en && (id_q == REQ_D);
    assign if_rvalid = if_rv_q;
    assign d_rvalid  = d_rv_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign busy      = (state_q != IDLE);
endmodule
